// File: rtl/io_responder.sv
// io_responder: LED output register and debounced switch read-back for the
// memory-mapped I/O decoder of a single-cycle CPU.
// Switch step to sw_db update latency is 2 (synchroniser) + 1 (IDLE to COUNT)
// + DB_CYCLES clock cycles.
module io_responder #(
   parameter int DB_CYCLES = 250000,
   parameter int CNT_W     = 18
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        LEDCtrl,
   input  logic        SwitchCtrl,
   input  logic [31:0] write_data,
   input  logic [23:0] switch_in,
   output logic [15:0] ioread_data,
   output logic [23:0] led_out
);

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } db_state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   db_state_t        state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [23:0]      sync1, sync2, prev;
   logic [23:0]      sw_db, sw_db_next;

   // Only the half-word select bits and the low store half-word are decoded.
   logic unused_bits;
   assign unused_bits = ^{address[31:2], write_data[31:16]};

   // LED register: half-word at offset 0, upper byte at offset 2.
   always_ff @(posedge clock) begin
      if (reset) begin
         led_out <= '0;
      end else if (LEDCtrl) begin
         case (address[1:0])
            2'b00:   led_out[15:0]  <= write_data[15:0];
            2'b10:   led_out[23:16] <= write_data[7:0];
            default: led_out        <= led_out;
         endcase
      end
   end

   // Two-flop synchroniser plus one extra stage to detect a still-bouncing input.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= switch_in;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   // Debounce state, counter and accepted switch value.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         sw_db <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         sw_db <= sw_db_next;
      end
   end

   // Group debounce: any movement restarts the count, a full stable run is accepted.
   always_comb begin
      state_next = state;
      cnt_next   = '0;
      sw_db_next = sw_db;
      case (state)
         IDLE: begin
            if (sync2 != sw_db) begin
               state_next = COUNT;
            end
         end
         COUNT: begin
            if (sync2 != prev) begin
               state_next = COUNT;
            end else if (sync2 == sw_db) begin
               state_next = IDLE;
            end else if (cnt == CNT_LAST) begin
               sw_db_next = sync2;
               state_next = IDLE;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Combinational read of the accepted switch value.
   always_comb begin
      ioread_data = 16'h0000;
      if (SwitchCtrl) begin
         case (address[1:0])
            2'b00:   ioread_data = sw_db[15:0];
            2'b10:   ioread_data = {8'h00, sw_db[23:16]};
            default: ioread_data = 16'h0000;
         endcase
      end
   end

endmodule

// File: tb/tb_io_responder.sv
// Directed testbench for io_responder with a short debounce window.
module tb_io_responder;

   localparam int DB_CYCLES = 4;
   localparam int CNT_W     = 3;
   localparam int LATENCY   = 2 + 1 + DB_CYCLES;

   logic        clock;
   logic        reset;
   logic [31:0] address;
   logic        LEDCtrl;
   logic        SwitchCtrl;
   logic [31:0] write_data;
   logic [23:0] switch_in;
   logic [15:0] ioread_data;
   logic [23:0] led_out;

   int vectorCount = 0;
   int missCount   = 0;

   io_responder #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .address    (address),
      .LEDCtrl    (LEDCtrl),
      .SwitchCtrl (SwitchCtrl),
      .write_data (write_data),
      .switch_in  (switch_in),
      .ioread_data(ioread_data),
      .led_out    (led_out)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic applyStimulus(input logic led_ctrl, input logic sw_ctrl,
                                input logic [31:0] addr, input logic [31:0] wdata);
      LEDCtrl    = led_ctrl;
      SwitchCtrl = sw_ctrl;
      address    = addr;
      write_data = wdata;
      #1;
   endtask

   // Expects the old read value for LATENCY-1 edges and the new one on edge LATENCY.
   task automatic debounceCheck(input string tag, input logic [15:0] old_val,
                                input logic [15:0] new_val);
      for (int i = 1; i < LATENCY; i++) begin
         tick();
         checkOutput({tag, "_wait"}, {16'h0, ioread_data}, {16'h0, old_val});
      end
      tick();
      checkOutput({tag, "_update"}, {16'h0, ioread_data}, {16'h0, new_val});
   endtask

   initial begin
      reset      = 1'b1;
      LEDCtrl    = 1'b0;
      SwitchCtrl = 1'b0;
      address    = 32'h0;
      write_data = 32'h0;
      switch_in  = 24'h0;
      $display("[TB] start");

      repeat (2) tick();
      reset = 1'b0;
      applyStimulus(1'b0, 1'b1, 32'hFFFFFC70, 32'h0);
      checkOutput("reset_led", {8'h0, led_out}, 32'h0);
      checkOutput("reset_read", {16'h0, ioread_data}, 32'h0);

      applyStimulus(1'b1, 1'b0, 32'hFFFFFC60, 32'h1234ABCD);
      tick();
      checkOutput("led_low_write", {8'h0, led_out}, 32'h00ABCD);
      applyStimulus(1'b1, 1'b0, 32'hFFFFFC62, 32'h000000FF);
      tick();
      checkOutput("led_high_write", {8'h0, led_out}, 32'hFFABCD);
      applyStimulus(1'b1, 1'b0, 32'hFFFFFC61, 32'h00005555);
      tick();
      checkOutput("led_addr01", {8'h0, led_out}, 32'hFFABCD);
      applyStimulus(1'b1, 1'b0, 32'hFFFFFC63, 32'h0000AAAA);
      tick();
      checkOutput("led_addr11", {8'h0, led_out}, 32'hFFABCD);
      applyStimulus(1'b0, 1'b0, 32'hFFFFFC60, 32'hDEADBEEF);
      repeat (10) tick();
      checkOutput("led_hold", {8'h0, led_out}, 32'hFFABCD);

      applyStimulus(1'b0, 1'b1, 32'hFFFFFC70, 32'h0);
      switch_in = 24'hA5F00F;
      debounceCheck("clean", 16'h0000, 16'hF00F);
      applyStimulus(1'b0, 1'b1, 32'hFFFFFC72, 32'h0);
      checkOutput("read_high", {16'h0, ioread_data}, 32'h00A5);
      applyStimulus(1'b0, 1'b1, 32'hFFFFFC71, 32'h0);
      checkOutput("read_addr01", {16'h0, ioread_data}, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'hFFFFFC73, 32'h0);
      checkOutput("read_addr11", {16'h0, ioread_data}, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'hFFFFFC70, 32'h0);
      checkOutput("read_deselect", {16'h0, ioread_data}, 32'h0);

      switch_in = 24'h0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      applyStimulus(1'b0, 1'b1, 32'hFFFFFC70, 32'h0);
      checkOutput("reset_clears_sw", {16'h0, ioread_data}, 32'h0);
      for (int k = 0; k < 20; k++) begin
         switch_in = ((k / 2) % 2 == 0) ? 24'h000001 : 24'h000000;
         tick();
         checkOutput("bounce_hold", {16'h0, ioread_data}, 32'h0);
      end
      switch_in = 24'h000001;
      debounceCheck("bounce_settle", 16'h0000, 16'h0001);

      switch_in = 24'h0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      applyStimulus(1'b0, 1'b1, 32'hFFFFFC70, 32'h0);
      switch_in = 24'h000100;
      repeat (3) begin
         tick();
         checkOutput("glitch_pulse", {16'h0, ioread_data}, 32'h0);
      end
      switch_in = 24'h000000;
      repeat (12) begin
         tick();
         checkOutput("glitch_after", {16'h0, ioread_data}, 32'h0);
      end
      switch_in = 24'h000F0F;
      debounceCheck("post_glitch", 16'h0000, 16'h0F0F);

      applyStimulus(1'b1, 1'b1, 32'hFFFFFC60, 32'h00001111);
      tick();
      checkOutput("led_pre_reset", {8'h0, led_out}, 32'h001111);
      applyStimulus(1'b0, 1'b1, 32'hFFFFFC70, 32'h0);
      switch_in = 24'h123456;
      repeat (5) begin
         tick();
         checkOutput("midcount_hold", {16'h0, ioread_data}, 32'h0F0F);
      end
      reset = 1'b1;
      applyStimulus(1'b1, 1'b1, 32'hFFFFFC60, 32'h00002222);
      tick();
      reset = 1'b0;
      applyStimulus(1'b0, 1'b1, 32'hFFFFFC70, 32'h0);
      checkOutput("midop_reset_led", {8'h0, led_out}, 32'h0);
      checkOutput("midop_reset_sw", {16'h0, ioread_data}, 32'h0);
      debounceCheck("post_reset", 16'h0000, 16'h3456);
      applyStimulus(1'b0, 1'b1, 32'hFFFFFC72, 32'h0);
      checkOutput("post_reset_high", {16'h0, ioread_data}, 32'h0012);
      checkOutput("post_reset_led", {8'h0, led_out}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Peripheral-side responder for the CPU's memory-mapped I/O decoder; it sits on the far side of the LED and switch chip-selects.
- Holds the 24-bit LED output register, written by sw instructions that target 0xFFFFFC60 and 0xFFFFFC62.
- Synchronises and debounces 24 board switches, and returns their value on the 16-bit ioread_data bus for lw instructions that target 0xFFFFFC70 and 0xFFFFFC72.
- Serves a single-cycle CPU, so reads are combinational from registered state and writes commit on the clock edge that ends the instruction.

Parameters:
- DB_CYCLES, 250000: consecutive stable cycles required before a switch change is accepted (10 ms at 25 MHz).
- CNT_W, 18: width of the debounce counter; must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- clock, input, 1: system clock, rising-edge.
- reset, input, 1: synchronous, active-high reset.
- address, input, 32: I/O address from the decoder; only address[1:0] is used.
- LEDCtrl, input, 1: LED chip select (iowrite qualified, 0xFFFFFC60..62).
- SwitchCtrl, input, 1: switch chip select (ioread qualified, 0xFFFFFC70..72).
- write_data, input, 32: store data from the decoder.
- switch_in, input, 24: raw asynchronous board switches.
- ioread_data, output, 16: read data to the decoder.
- led_out, output, 24: LED drive.

Behaviour:
- One clock domain. Reset is synchronous and active-high: sampled on a clock rising edge while reset=1.
- Reset values:
  - led_out = 0.
  - Synchroniser stages sync1 and sync2 = 0.
  - Previous sample prev = 0.
  - Debounced register sw_db = 0.
  - Counter cnt = 0.
  - ioread_data = 0.
- Reset mid-debounce discards the pending change. After reset is released, sw_db stays 0 until a full debounce of the raw input completes.

LED write path (registered, effective on the edge where LEDCtrl=1):
- address[1:0]=00: led_out[15:0] <= write_data[15:0]; led_out[23:16] unchanged.
- address[1:0]=10: led_out[23:16] <= write_data[7:0]; led_out[15:0] unchanged; write_data[31:8] ignored.
- address[1:0]=01 or 11: no update.
- LEDCtrl=0: led_out holds its value.
- reset has priority over a simultaneous write.

Switch synchroniser:
- sync1 <= switch_in; sync2 <= sync1; prev <= sync2, every cycle.
- Input to sw_db therefore has 2 cycles of synchroniser latency.

Debounce FSM (group debounce, all 24 bits together):
- IDLE:
  - sync2 == sw_db: cnt <= 0, stay in IDLE.
  - sync2 != sw_db: cnt <= 0, go to COUNT.
- COUNT:
  - sync2 != prev (input still bouncing): cnt <= 0, stay in COUNT.
  - sync2 == sw_db (bounced back to the accepted value): cnt <= 0, go to IDLE.
  - cnt == DB_CYCLES-1: sw_db <= sync2, cnt <= 0, go to IDLE.
  - otherwise: cnt <= cnt+1.
- The counter never wraps; it saturates at DB_CYCLES-1 by construction.
- Latency from a clean switch_in step to sw_db update is 2 (synchroniser) + 1 (IDLE to COUNT) + DB_CYCLES cycles. This figure must be documented and checked exactly.

Switch read path (combinational):
- SwitchCtrl=1, address[1:0]=00: ioread_data = sw_db[15:0].
- SwitchCtrl=1, address[1:0]=10: ioread_data = {8'h00, sw_db[23:16]}.
- SwitchCtrl=1, address[1:0]=01 or 11: ioread_data = 0.
- SwitchCtrl=0: ioread_data = 0.
- A read in the same cycle as an sw_db update returns the old value. The new value is visible from the next cycle.

Chip-select rules:
- LEDCtrl and SwitchCtrl are mutually exclusive by the decoder. If both are high, each path acts independently; there is no interaction.

Test Plan:
- Reset then write: hold reset 1 cycle, then LEDCtrl=1, address=0xFFFFFC60, write_data=0x1234ABCD -> led_out=0x00ABCD. Then address=0xFFFFFC62, write_data=0x000000FF -> led_out=0xFFABCD.
- Invalid address and hold: LEDCtrl=1, address=0xFFFFFC61, write_data=0x5555 -> led_out unchanged. LEDCtrl=0 for 10 cycles -> led_out unchanged.
- Clean debounce (DB_CYCLES=4): switch_in steps 0 -> 0xA5F00F.
  - sw_db changes exactly 7 cycles after the step.
  - SwitchCtrl=1 at 0xFFFFFC70 -> 0xF00F; at 0xFFFFFC72 -> 0x00A5.
  - SwitchCtrl=0 -> 0x0000.
- Bounce rejection (DB_CYCLES=4): switch_in toggles bit0 every 2 cycles for 20 cycles, then holds at 1 -> sw_db stays 0 throughout the bouncing and becomes 0x000001 7 cycles after the final edge.
- Glitch return: switch_in pulses 0x000100 for 3 cycles, then returns to 0 -> sw_db never changes and the FSM returns to IDLE.
- Reset mid-operation: assert reset at cycle 3 of a COUNT and during an LED write -> led_out=0 and sw_db=0. After release with the input held, sw_db updates a full 7 cycles later.
